control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Eight-phase instruction sequencer for the VeriRISC core.
- It sits directly upstream of the program counter and drives the counter's load (ld_pc) and enable (inc_pc) controls.
- It also drives memory read/write, IR load, accumulator load and data-bus enable from the current phase and the decoded opcode.
- One instruction completes every 8 clocks unless the processor is halted.

Parameters:
- None. Opcode width is fixed at 3 bits and phase width is fixed at 3 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- opcode  input  3  from the instruction register: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7
- zero  input  1  accumulator-is-zero flag
- sel  output  1  address mux select; 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC count enable (drives counter enab)
- halt  output  1  processor halted
- ld_pc  output  1  PC load (drives counter load)
- data_e  output  1  data bus drive enable (store)
- ld_ac  output  1  accumulator load
- wr  output  1  memory write strobe

Behaviour:
- State is a 3-bit phase register and a 1-bit halted flag.
- Phases: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Reset: rst=1 at a rising edge sets phase=INST_ADDR and clears halted. rst has priority over every other condition, including mid-instruction and while halted.
- Advance: phase increments by 1 each clock and wraps 7 -> 0.
- HLT entry: if phase=OP_ADDR and opcode=HLT, halted is set at that edge and phase holds at OP_ADDR.
- Halted state: phase stays frozen until rst.
- Output decode: all outputs are combinational from phase, opcode, zero and halted; there are no output registers, so outputs follow phase in the same cycle.
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Output decode per phase (all unlisted outputs are 0):
  - INST_ADDR: sel=1
  - INST_FETCH: sel=1, rd=1
  - INST_LOAD: sel=1, rd=1, ld_ir=1
  - IDLE: sel=1, rd=1, ld_ir=1
  - OP_ADDR: inc_pc=1 (not asserted while halted); halt=(opcode==HLT) or halted
  - OP_FETCH: rd=ALUOP
  - ALU_OP: rd=ALUOP, inc_pc=(opcode==SKZ and zero), ld_pc=(opcode==JMP), data_e=(opcode==STO)
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=(opcode==JMP), wr=(opcode==STO), data_e=(opcode==STO)
- halt output: asserted whenever halted=1, regardless of phase.
- While halted, every other output is 0 except sel (sel=0).
- Invariants:
  - ld_pc and inc_pc are never both 1 in any cycle.
  - wr only asserts in STORE.
  - Reset-cycle outputs are those of INST_ADDR: sel=1, all others 0.
- Unknown/X opcode: outputs follow the decode table; no special handling is required.

Optional Feature:
- Macro: CTRL_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - Phase advances from STORE to INST_ADDR only on a clock where step=1; otherwise phase holds at STORE with wr/ld_ac/ld_pc deasserted after the first STORE cycle (single strobe per instruction).
  - rst still overrides.
- When not defined: no step port; free-running 8-phase cycle as above.

Test Plan:
- Reset and walk: rst=1 for 1 clk, then opcode=ADD, zero=0.
  - Phase 0 -> sel=1 only.
  - Phases 5-7 -> rd=1; phase 7 -> ld_ac=1.
  - Phase wraps to 0 after 8 clks; inc_pc=1 only in phase 4.
- Jump: opcode=JMP -> ld_pc=1 in phases 6 and 7, inc_pc=1 in phase 4 only, rd=0 in phases 5-7.
- Skip on zero: opcode=SKZ.
  - zero=1 -> inc_pc=1 in phases 4 and 6.
  - zero=0 -> inc_pc=1 in phase 4 only.
- Store: opcode=STO -> data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 and ld_ac=0 throughout.
- Halt and recovery: opcode=HLT at phase 4 -> halt=1.
  - Phase frozen at 4 for 20 clks; inc_pc=0 after the entry cycle.
  - rst=1 -> phase=0, halt=0 next cycle.
- Reset mid-instruction: assert rst in phase 6 with opcode=STO -> next cycle phase=0, wr never asserted.
- Single step (with CTRL_SINGLE_STEP_EN): step=0 -> phase held at 7, wr pulses 1 clk only; step=1 -> phase 0 next clk.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer: eight-phase VeriRISC instruction sequencer driving PC, memory, IR and ACC controls.
// Build macro CTRL_SINGLE_STEP_EN adds a step input that holds the STORE phase until released.
module control_sequencer (
   input  logic       clk,
   input  logic       rst,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic       step,
`endif
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       halt,
   output logic       ld_pc,
   output logic       data_e,
   output logic       ld_ac,
   output logic       wr
);

   localparam logic [2:0] PH_INST_ADDR  = 3'd0;
   localparam logic [2:0] PH_INST_FETCH = 3'd1;
   localparam logic [2:0] PH_INST_LOAD  = 3'd2;
   localparam logic [2:0] PH_IDLE       = 3'd3;
   localparam logic [2:0] PH_OP_ADDR    = 3'd4;
   localparam logic [2:0] PH_OP_FETCH   = 3'd5;
   localparam logic [2:0] PH_ALU_OP     = 3'd6;
   localparam logic [2:0] PH_STORE      = 3'd7;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   function automatic logic is_aluop(input logic [2:0] op);
      case (op)
         OP_ADD, OP_AND, OP_XOR, OP_LDA: is_aluop = 1'b1;
         default:                        is_aluop = 1'b0;
      endcase
   endfunction

   logic [2:0] phase_r;
   logic [2:0] next_phase_s;
   logic       halted_r;
   logic       next_halted_s;
   logic       store_hold_r;
   logic       next_store_hold_s;
   logic       aluop_s;

   assign aluop_s = is_aluop(opcode);

   // State register: phase, halted flag and STORE-hold marker.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_r      <= PH_INST_ADDR;
         halted_r     <= 1'b0;
         store_hold_r <= 1'b0;
      end else begin
         phase_r      <= next_phase_s;
         halted_r     <= next_halted_s;
         store_hold_r <= next_store_hold_s;
      end
   end

   // Next-state logic: free-running advance, HLT freeze, optional STORE hold.
   always_comb begin
      next_phase_s      = phase_r;
      next_halted_s     = halted_r;
      next_store_hold_s = 1'b0;
      if (halted_r) begin
         next_phase_s  = phase_r;
         next_halted_s = 1'b1;
      end else if ((phase_r == PH_OP_ADDR) && (opcode == OP_HLT)) begin
         next_phase_s  = PH_OP_ADDR;
         next_halted_s = 1'b1;
      end else if (phase_r == PH_STORE) begin
`ifdef CTRL_SINGLE_STEP_EN
         if (step) begin
            next_phase_s      = PH_INST_ADDR;
            next_store_hold_s = 1'b0;
         end else begin
            next_phase_s      = PH_STORE;
            next_store_hold_s = 1'b1;
         end
`else
         next_phase_s = PH_INST_ADDR;
`endif
      end else begin
         next_phase_s = phase_r + 3'd1;
      end
   end

   // Output decode from phase, opcode, zero flag and halted state.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      halt   = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      if (halted_r) begin
         halt = 1'b1;
      end else begin
         case (phase_r)
            PH_INST_ADDR: begin
               sel = 1'b1;
            end
            PH_INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == OP_HLT);
            end
            PH_OP_FETCH: begin
               rd = aluop_s;
            end
            PH_ALU_OP: begin
               rd     = aluop_s;
               inc_pc = (opcode == OP_SKZ) && zero;
               ld_pc  = (opcode == OP_JMP);
               data_e = (opcode == OP_STO);
            end
            PH_STORE: begin
               rd     = aluop_s;
               data_e = (opcode == OP_STO);
               // Strobes fire only on the first STORE cycle when the phase is being held.
               if (store_hold_r) begin
                  ld_ac = 1'b0;
                  ld_pc = 1'b0;
                  wr    = 1'b0;
               end else begin
                  ld_ac = aluop_s;
                  ld_pc = (opcode == OP_JMP);
                  wr    = (opcode == OP_STO);
               end
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven, hand-sequenced and randomized checks of control_sequencer.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
`ifdef CTRL_SINGLE_STEP_EN
   logic       step = 1'b1;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   control_sequencer dut (
      .clk    (clk),
      .rst    (rst),
`ifdef CTRL_SINGLE_STEP_EN
      .step   (step),
`endif
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .halt   (halt),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr)
   );

   // Output vector order: {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr}
   logic [8:0] outs;
   assign outs = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   localparam logic [8:0] E_P0   = 9'b100000000;
   localparam logic [8:0] E_P1   = 9'b110000000;
   localparam logic [8:0] E_P23  = 9'b111000000;
   localparam logic [8:0] E_P4   = 9'b000100000;
   localparam logic [8:0] E_NONE = 9'b000000000;
   localparam logic [8:0] E_HLT  = 9'b000010000;

   typedef struct {
      logic [2:0] op;
      logic       z;
      logic [8:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic add_instr(input string nm, input logic [2:0] op, input logic z,
                            input logic [8:0] e5, input logic [8:0] e6, input logic [8:0] e7);
      vecs.push_back('{op, z, E_P0,  {nm, "_p0"}});
      vecs.push_back('{op, z, E_P1,  {nm, "_p1"}});
      vecs.push_back('{op, z, E_P23, {nm, "_p2"}});
      vecs.push_back('{op, z, E_P23, {nm, "_p3"}});
      vecs.push_back('{op, z, E_P4,  {nm, "_p4"}});
      vecs.push_back('{op, z, e5,    {nm, "_p5"}});
      vecs.push_back('{op, z, e6,    {nm, "_p6"}});
      vecs.push_back('{op, z, e7,    {nm, "_p7"}});
   endtask

   // Reference expectations written directly from the phase rules.
   function automatic logic [8:0] model(input int ph, input bit hl, input logic [2:0] op, input bit z);
      bit alu, s, r, li, ip, h, lp, de, la, w;
      alu = (op >= 3'd2) && (op <= 3'd5);
      if (hl) return E_HLT;
      s  = (ph <= 3);
      r  = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
      li = (ph == 2) || (ph == 3);
      ip = (ph == 4) || (ph == 6 && op == 3'd1 && z);
      h  = (ph == 4) && (op == 3'd0);
      lp = (ph >= 6) && (op == 3'd7);
      de = (ph >= 6) && (op == 3'd6);
      la = (ph == 7) && alu;
      w  = (ph == 7) && (op == 3'd6);
      return {s, r, li, ip, h, lp, de, la, w};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int         m_ph;
   bit         m_hl;
   logic [2:0] rop;
   bit         rrst;

   initial begin
      add_instr("add",   3'd2, 1'b0, 9'b010000000, 9'b010000000, 9'b010000010);
      add_instr("jmp",   3'd7, 1'b0, E_NONE,       9'b000001000, 9'b000001000);
      add_instr("skz_z1",3'd1, 1'b1, E_NONE,       9'b000100000, E_NONE);
      add_instr("skz_z0",3'd1, 1'b0, E_NONE,       E_NONE,       E_NONE);
      add_instr("sto",   3'd6, 1'b0, E_NONE,       9'b000000100, 9'b000000101);
      add_instr("lda_z1",3'd5, 1'b1, 9'b010000000, 9'b010000000, 9'b010000010);

      rst = 1'b1; opcode = 3'd2; zero = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // Table walk: one record per clock starting at phase 0.
      foreach (vecs[i]) begin
         opcode = vecs[i].op;
         zero   = vecs[i].z;
         #2 check(vecs[i].name, outs, vecs[i].exp);
         tick();
      end

      // Halt entry, freeze and recovery.
      opcode = 3'd0;
      #2 check("hlt_p0", outs, E_P0);
      tick(); tick(); tick(); tick();
      #2 check("hlt_entry", outs, 9'b000110000);
      tick();
      for (int i = 0; i < 20; i++) begin
         opcode = 3'($urandom_range(0, 7));
         zero   = 1'($urandom_range(0, 1));
         #2 check("halted", outs, E_HLT);
         tick();
      end
      rst = 1'b1;
      #2 check("halted_rst_cycle", outs, E_HLT);
      tick();
      rst = 1'b0; opcode = 3'd2; zero = 1'b0;
      #2 check("post_halt_reset", outs, E_P0);
      tick();
      opcode = 3'd2;
      #2 check("post_halt_p1", outs, E_P1);

      // Reset in ALU_OP with STO pending.
      opcode = 3'd6;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      #2 check("rst_mid_p6", outs, 9'b000000100);
      tick();
      rst = 1'b0;
      #2 check("rst_mid_after", outs, E_P0);

`ifdef CTRL_SINGLE_STEP_EN
      rst = 1'b1; tick(); rst = 1'b0;
      opcode = 3'd6; step = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      step = 1'b0;
      #2 check("step_store_first", outs, 9'b000000101);
      tick();
      for (int i = 0; i < 3; i++) begin
         #2 check("step_store_hold", outs, 9'b000000100);
         tick();
      end
      step = 1'b1;
      #2 check("step_release_cycle", outs, 9'b000000100);
      tick();
      #2 check("step_next_p0", outs, E_P0);
`endif

      // Randomized run against the behavioural model.
      rst = 1'b1; tick(); rst = 1'b0;
      m_ph = 0; m_hl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         rrst   = ($urandom_range(0, 39) == 0);
         rop    = 3'($urandom_range(0, 7));
         rst    = rrst;
         opcode = rop;
         zero   = 1'($urandom_range(0, 1));
         #2 check("random", outs, model(m_ph, m_hl, rop, zero));
         if ((ld_pc & inc_pc) !== 1'b0) begin
            checks++; errors++;
            $display("FAIL ld_pc_inc_pc_excl: got ld_pc=%b inc_pc=%b required not both 1", ld_pc, inc_pc);
         end
         tick();
         if (rrst) begin
            m_ph = 0; m_hl = 1'b0;
         end else if (m_hl) begin
            m_ph = m_ph;
         end else if (m_ph == 4 && rop == 3'd0) begin
            m_hl = 1'b1;
         end else begin
            m_ph = (m_ph + 1) % 8;
         end
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
